adder_result_checker: RTL and testbench

//  Receive-side scoreboard for the 16-bit adder datapath: captures each operand pair as issued, queues the golden a+b,

---
 rtl/adder_chk_if.sv | 15 +
 rtl/adder_result_checker.sv | 154 +++++++++++++++
 tb/tb_adder_result_checker.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/adder_chk_if.sv
// Stimulus/result bus seen by the adder scoreboard: operand issue, DUT sum return
// and the end-of-stimulus request.
interface adder_chk_if #(
  parameter int W = 16
);
  logic         op_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sum_valid;
  logic [W:0]   sum;
  logic         done;

  modport master (output op_valid, a, b, sum_valid, sum, done);
  modport slave  (input  op_valid, a, b, sum_valid, sum, done);
endinterface

// File: rtl/adder_result_checker.sv
// In-order scoreboard for a W-bit adder: queues golden a+b per issued operand pair,
// compares against returned sums, counts results and issues a final verdict.
module adder_result_checker #(
  parameter int W       = 16,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  adder_chk_if.slave                 bus,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic [CNT_W-1:0]           fail_cnt,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic [W:0]                 first_exp,
  output logic [W:0]                 first_got,
  output logic                       proto_err,
  output logic                       finished,
  output logic                       passed
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_PASS  = 2'd2;
  localparam logic [1:0] S_FAIL  = 2'd3;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [W:0]       mem_q [DEPTH];
  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic [W:0]       fexp_q, fexp_d, fgot_q, fgot_d;
  logic             fseen_q, fseen_d;
  logic             proto_q, proto_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic             active, push_req, pop_req, empty, full, do_push, do_pop;
  logic [W:0]       head, golden;

  always_comb begin
    active   = (state_q == S_RUN) || (state_q == S_DRAIN);
    push_req = (state_q == S_RUN) && bus.op_valid;
    pop_req  = active && bus.sum_valid;
    empty    = (cnt_q == '0);
    full     = (cnt_q == CW'(DEPTH));
    do_pop   = pop_req && !empty;
    // A pop in the same cycle frees a slot, so a push into a full queue is legal then.
    do_push  = push_req && (!full || do_pop);
    head     = mem_q[rd_q];
    golden   = {1'b0, bus.a} + {1'b0, bus.b};

    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    fexp_d  = fexp_q;
    fgot_d  = fgot_q;
    fseen_d = fseen_q;
    proto_d = proto_q;
    timer_d = timer_q;

    if (push_req && !do_push)                   proto_d = 1'b1;
    if (pop_req && empty)                       proto_d = 1'b1;
    if ((state_q == S_DRAIN) && bus.op_valid)   proto_d = 1'b1;

    if (do_pop) begin
      rd_d = rd_q + AW'(1);
      if (head == bus.sum) begin
        pass_d = sat_inc(pass_q);
      end else begin
        fail_d = sat_inc(fail_q);
        if (!fseen_q) begin
          fseen_d = 1'b1;
          fexp_d  = head;
          fgot_d  = bus.sum;
        end
      end
    end

    if (do_push) wr_d = wr_q + AW'(1);

    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);

    case (state_q)
      S_RUN: begin
        if (bus.done) begin
          state_d = S_DRAIN;
          timer_d = '0;
        end
      end
      S_DRAIN: begin
        timer_d = timer_q + TW'(1);
        // Verdict uses this cycle's updates so a final pop is counted.
        if (cnt_d == '0)
          state_d = ((fail_d == '0) && !proto_d) ? S_PASS : S_FAIL;
        else if (timer_q >= TW'(TIMEOUT - 1))
          state_d = S_FAIL;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      fexp_q  <= '0;
      fgot_q  <= '0;
      fseen_q <= 1'b0;
      proto_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      fexp_q  <= fexp_d;
      fgot_q  <= fgot_d;
      fseen_q <= fseen_d;
      proto_q <= proto_d;
      timer_q <= timer_d;
    end
  end

  // Queue storage holds data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= golden;
  end

  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;
  assign outstanding = cnt_q;
  assign first_exp   = fexp_q;
  assign first_got   = fgot_q;
  assign proto_err   = proto_q;
  assign finished    = (state_q == S_PASS) || (state_q == S_FAIL);
  assign passed      = (state_q == S_PASS);
endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker: carry handling, overflow/underflow,
// mismatch capture, drain timeout and mid-drain reset.
module tb_adder_result_checker;
  localparam int W = 16, DEPTH = 8, CNT_W = 16, TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [CNT_W-1:0]       pass_cnt, fail_cnt;
  logic [$clog2(DEPTH):0] outstanding;
  logic [W:0]             first_exp, first_got;
  logic                   proto_err, finished, passed;

  int n_chk  = 0;
  int n_fail = 0;

  adder_chk_if #(.W(W)) bus ();

  adder_result_checker #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .outstanding(outstanding),
    .first_exp(first_exp), .first_got(first_got), .proto_err(proto_err),
    .finished(finished), .passed(passed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.op_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.sum_valid = 1'b0; bus.sum = '0; bus.done = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    idle();
    bus.op_valid = 1'b1; bus.a = a; bus.b = b;
    cyc();
    idle();
  endtask

  task automatic ret(input logic [W:0] s);
    idle();
    bus.sum_valid = 1'b1; bus.sum = s;
    cyc();
    idle();
  endtask

  task automatic finish_run(input int max_cyc);
    idle();
    bus.done = 1'b1;
    cyc();
    idle();
    for (int i = 0; i < max_cyc && !finished; i++) cyc();
  endtask

  logic [W:0] exp5 [6];

  initial begin
    idle();
    do_reset();
    check("rst_pass", 32'(pass_cnt), 0);
    check("rst_fail", 32'(fail_cnt), 0);
    check("rst_out", 32'(outstanding), 0);
    check("rst_proto", 32'(proto_err), 0);
    check("rst_fin", 32'(finished), 0);
    check("rst_exp", 32'(first_exp), 0);

    // Basic match then verdict PASS
    push(16'h1234, 16'h0001);
    check("t1_out", 32'(outstanding), 1);
    ret(17'h01235);
    check("t1_pass", 32'(pass_cnt), 1);
    check("t1_out0", 32'(outstanding), 0);
    finish_run(10);
    check("t1_fin", 32'(finished), 1);
    check("t1_passed", 32'(passed), 1);

    // Carry retained in golden sum
    do_reset();
    push(16'hFFFF, 16'hFFFF);
    ret(17'h1FFFE);
    check("t2_pass", 32'(pass_cnt), 1);
    push(16'hFFFF, 16'hFFFF);
    ret(17'h0FFFE);
    check("t2_fail", 32'(fail_cnt), 1);
    check("t2_exp", 32'(first_exp), 32'h1FFFE);
    check("t2_got", 32'(first_got), 32'h0FFFE);

    // Overflow, and full-queue push with simultaneous pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(W'(i), W'(i));
    check("t3_full", 32'(outstanding), 8);
    check("t3_noerr", 32'(proto_err), 0);
    push(16'h0100, 16'h0001);
    check("t3_ovf", 32'(proto_err), 1);
    check("t3_out8", 32'(outstanding), 8);
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(W'(i), W'(i));
    bus.op_valid = 1'b1; bus.a = 16'h0005; bus.b = 16'h0005;
    bus.sum_valid = 1'b1; bus.sum = 17'h00000;
    cyc();
    idle();
    check("t3_pp_err", 32'(proto_err), 0);
    check("t3_pp_out", 32'(outstanding), 8);
    check("t3_pp_pass", 32'(pass_cnt), 1);

    // Underflow
    do_reset();
    ret(17'h00042);
    check("t4_proto", 32'(proto_err), 1);
    check("t4_pass", 32'(pass_cnt), 0);
    check("t4_fail", 32'(fail_cnt), 0);
    finish_run(10);
    check("t4_fin", 32'(finished), 1);
    check("t4_passed", 32'(passed), 0);

    // Mismatches on results 2 and 5 of 6
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp5[i] = 17'((i + 1) * 16'h0100 + (i + 1));
      push(W'((i + 1) * 16'h0100), W'(i + 1));
    end
    for (int i = 0; i < 6; i++) ret((i == 1 || i == 4) ? (exp5[i] ^ 17'h00001) : exp5[i]);
    check("t5_fail", 32'(fail_cnt), 2);
    check("t5_pass", 32'(pass_cnt), 4);
    check("t5_exp", 32'(first_exp), 32'h00202);
    check("t5_got", 32'(first_got), 32'h00203);
    finish_run(10);
    check("t5_passed", 32'(passed), 0);
    check("t5_fin", 32'(finished), 1);

    // Drain timeout with one sum missing
    do_reset();
    push(16'h0001, 16'h0002);
    push(16'h0003, 16'h0004);
    push(16'h0005, 16'h0006);
    idle();
    bus.done = 1'b1;
    cyc();
    ret(17'h00003);
    ret(17'h00007);
    for (int i = 0; i < TIMEOUT + 20 && !finished; i++) cyc();
    check("t6_fin", 32'(finished), 1);
    check("t6_passed", 32'(passed), 0);
    check("t6_out", 32'(outstanding), 1);
    check("t6_pass", 32'(pass_cnt), 2);

    // Reset in the middle of DRAIN
    do_reset();
    push(16'h0010, 16'h0020);
    push(16'h0030, 16'h0040);
    idle();
    bus.done = 1'b1;
    cyc();
    do_reset();
    check("t7_out", 32'(outstanding), 0);
    check("t7_fin", 32'(finished), 0);
    check("t7_proto", 32'(proto_err), 0);
    push(16'h0001, 16'h0001);
    check("t7_run", 32'(outstanding), 1);
    check("t7_proto2", 32'(proto_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
